// File: rtl/c_fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : c_fetch_pkg
//  Description : Shared types, constants and helpers for the fetch realigner.
//  Revision    : 1.0 - initial release
// ============================================================================
package c_fetch_pkg;

    typedef enum logic [0:0] {
        S_ALIGN = 1'b0,
        S_RUN   = 1'b1
    } rb_state_e;

    localparam logic [31:0] c_nop = 32'h0000_0013;

    // Number of 16-bit halfwords carried by one fetch word.
    function automatic int fetch_hw(input int fetch_w);
        return fetch_w / 16;
    endfunction

    function automatic logic is_rvc(input logic [15:0] hw);
        return hw[1:0] != 2'b11;
    endfunction

endpackage
`default_nettype wire

// File: rtl/c_hw_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : c_hw_fifo
//  Description : Halfword circular FIFO. Pushes up to FETCH_HW halfwords per
//                cycle starting at a slot offset, pops 1 or 2 per cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module c_hw_fifo #(
    parameter int FETCH_HW = 2,
    parameter int BUF_HW   = 8,
    localparam int PTR_W   = $clog2(BUF_HW),
    localparam int CNT_W   = $clog2(BUF_HW + 1),
    localparam int SKIP_W  = (FETCH_HW > 1) ? $clog2(FETCH_HW) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   push_en,
    input  logic [SKIP_W-1:0]      push_skip,
    input  logic [FETCH_HW*16-1:0] push_data,
    input  logic                   pop_en,
    input  logic                   pop_two,
    output logic [15:0]            head0,
    output logic [15:0]            head1,
    output logic [CNT_W-1:0]       count
);

    logic [15:0]      r_mem [BUF_HW];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;

    logic [CNT_W-1:0] w_push_cnt;
    logic [CNT_W-1:0] w_pop_cnt;
    logic [PTR_W-1:0] w_rd_ptr_p1;
    logic             w_slot_en  [FETCH_HW];
    logic [PTR_W-1:0] w_slot_idx [FETCH_HW];

    assign w_push_cnt  = push_en ? (CNT_W'(FETCH_HW) - CNT_W'(push_skip)) : '0;
    assign w_pop_cnt   = pop_en ? (pop_two ? CNT_W'(2) : CNT_W'(1)) : '0;
    assign w_rd_ptr_p1 = r_rd_ptr + PTR_W'(1);

    // Slot j lands at wr_ptr + (j - skip) so skipped leading slots leave no hole.
    for (genvar j = 0; j < FETCH_HW; j++) begin : g_slot
        assign w_slot_en[j]  = push_en && (SKIP_W'(j) >= push_skip);
        assign w_slot_idx[j] = r_wr_ptr + PTR_W'(j) - PTR_W'(push_skip);
    end

    always_ff @(posedge clk) begin
        for (int j = 0; j < FETCH_HW; j++) begin
            if (w_slot_en[j]) begin
                r_mem[w_slot_idx[j]] <= push_data[j*16 +: 16];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(w_push_cnt);
            r_rd_ptr <= r_rd_ptr + PTR_W'(w_pop_cnt);
            r_count  <= r_count + w_push_cnt - w_pop_cnt;
        end
    end

    assign head0 = r_mem[r_rd_ptr];
    assign head1 = r_mem[w_rd_ptr_p1];
    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/c_fetch_realign_buf.sv
`default_nettype none
// ============================================================================
//  Module      : c_fetch_realign_buf
//  Description : RV32IC fetch realignment buffer between I-cache and decode;
//                emits one aligned instruction per cycle with PC and RVC flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module c_fetch_realign_buf
    import c_fetch_pkg::*;
#(
    parameter int          FETCH_W  = 32,
    parameter int          BUF_HW   = 8,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         sel_for_branch,
    input  logic [31:0]                  redirect_pc_i,
    input  logic                         fetch_valid_i,
    input  logic [31:0]                  fetch_pc_i,
    input  logic [FETCH_W-1:0]           fetch_data_i,
    output logic                         fetch_ready_o,
    output logic                         inst_valid_o,
    input  logic                         inst_ready_i,
    output logic [31:0]                  inst_o,
    output logic                         inst_is_c_o,
    output logic [31:0]                  pc_o,
    output logic [$clog2(BUF_HW+1)-1:0]  occupancy_o
);

    localparam int          c_fetch_hw    = fetch_hw(FETCH_W);
    localparam int          c_fetch_bytes = FETCH_W / 8;
    localparam int          c_off_w       = $clog2(c_fetch_bytes);
    localparam int          c_skip_w      = c_off_w - 1;
    localparam int          c_cnt_w       = $clog2(BUF_HW + 1);
    localparam logic [31:0] c_align_mask  = ~(32'(c_fetch_bytes) - 32'd1);
    localparam logic [c_skip_w-1:0] c_reset_skip = RESET_PC[c_off_w-1:1];

    rb_state_e             r_state;
    rb_state_e             w_state_nxt;
    logic [31:0]           r_pc;
    logic [31:0]           r_exp_pc;
    logic [c_skip_w-1:0]   r_skip;

    logic                  w_accept;
    logic                  w_match;
    logic [c_skip_w-1:0]   w_push_skip;
    logic [15:0]           w_hw0;
    logic [15:0]           w_hw1;
    logic [c_cnt_w-1:0]    w_count;
    logic                  w_is_c;
    logic                  w_inst_valid;
    logic                  w_pop;

    // Ready is a function of the pre-pop count only, keeping inst_ready_i off this path.
    assign fetch_ready_o = (w_count <= c_cnt_w'(BUF_HW - c_fetch_hw));
    assign w_accept      = fetch_valid_i & fetch_ready_o & ~sel_for_branch;
    assign w_match       = w_accept & (fetch_pc_i == r_exp_pc);

    c_hw_fifo #(
        .FETCH_HW (c_fetch_hw),
        .BUF_HW   (BUF_HW)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (sel_for_branch),
        .push_en   (w_match),
        .push_skip (w_push_skip),
        .push_data (fetch_data_i),
        .pop_en    (w_pop),
        .pop_two   (~w_is_c),
        .head0     (w_hw0),
        .head1     (w_hw1),
        .count     (w_count)
    );

    // Head decode: a 32-bit head with only one halfword present waits for the next word.
    assign w_is_c       = is_rvc(w_hw0);
    assign w_inst_valid = ~sel_for_branch &
                          (w_is_c ? (w_count != '0) : (w_count >= c_cnt_w'(2)));
    assign w_pop        = w_inst_valid & inst_ready_i;

    assign inst_valid_o = w_inst_valid;
    assign inst_is_c_o  = w_is_c;
    assign inst_o       = w_is_c ? {16'h0000, w_hw0} : {w_hw1, w_hw0};
    assign pc_o         = r_pc;
    assign occupancy_o  = w_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_ALIGN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_push_skip = '0;
        case (r_state)
            S_ALIGN: begin
                w_push_skip = r_skip;
                if (w_match) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                w_state_nxt = S_RUN;
            end
        endcase
        if (sel_for_branch) begin
            w_state_nxt = S_ALIGN;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc     <= RESET_PC;
            r_exp_pc <= RESET_PC & c_align_mask;
            r_skip   <= c_reset_skip;
        end else if (sel_for_branch) begin
            r_pc     <= redirect_pc_i & ~32'h1;
            r_exp_pc <= redirect_pc_i & c_align_mask;
            r_skip   <= redirect_pc_i[c_off_w-1:1];
        end else begin
            if (w_pop) begin
                r_pc <= r_pc + (w_is_c ? 32'd2 : 32'd4);
            end
            if (w_match) begin
                r_exp_pc <= r_exp_pc + 32'(c_fetch_bytes);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_c_fetch_realign_buf.sv
`default_nettype none
// ============================================================================
//  Module      : tb_c_fetch_realign_buf
//  Description : Directed vector bench for 32-bit and 64-bit fetch variants.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_c_fetch_realign_buf;

    typedef struct {
        logic        fv;
        logic [31:0] fpc;
        logic [63:0] fdata;
        logic        rdy;
        logic        br;
        logic [31:0] bpc;
        logic        ev;
        logic [31:0] einst;
        logic        ec;
        logic [31:0] epc;
        logic        efr;
        logic [3:0]  eocc;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        fv32 = 0, rdy32 = 0, br32 = 0;
    logic [31:0] fpc32 = 0, fd32 = 0, bpc32 = 0;
    logic        fr32, iv32, isc32;
    logic [31:0] inst32, pc32;
    logic [3:0]  occ32;

    logic        fv64 = 0, rdy64 = 0, br64 = 0;
    logic [31:0] fpc64 = 0, bpc64 = 0;
    logic [63:0] fd64 = 0;
    logic        fr64, iv64, isc64;
    logic [31:0] inst64, pc64;
    logic [3:0]  occ64;

    int n_checks = 0;
    int n_errors = 0;

    c_fetch_realign_buf #(.FETCH_W(32), .BUF_HW(8), .RESET_PC(32'h0)) dut32 (
        .clk(clk), .reset(reset), .sel_for_branch(br32), .redirect_pc_i(bpc32),
        .fetch_valid_i(fv32), .fetch_pc_i(fpc32), .fetch_data_i(fd32),
        .fetch_ready_o(fr32), .inst_valid_o(iv32), .inst_ready_i(rdy32),
        .inst_o(inst32), .inst_is_c_o(isc32), .pc_o(pc32), .occupancy_o(occ32)
    );

    c_fetch_realign_buf #(.FETCH_W(64), .BUF_HW(8), .RESET_PC(32'h6)) dut64 (
        .clk(clk), .reset(reset), .sel_for_branch(br64), .redirect_pc_i(bpc64),
        .fetch_valid_i(fv64), .fetch_pc_i(fpc64), .fetch_data_i(fd64),
        .fetch_ready_o(fr64), .inst_valid_o(iv64), .inst_ready_i(rdy64),
        .inst_o(inst64), .inst_is_c_o(isc64), .pc_o(pc64), .occupancy_o(occ64)
    );

    function automatic vec_t mk(logic fv, logic [31:0] fpc, logic [63:0] fd, logic rdy,
                                logic br, logic [31:0] bpc, logic ev, logic [31:0] ei,
                                logic ec, logic [31:0] epc, logic efr, logic [3:0] eocc);
        vec_t v;
        v.fv = fv; v.fpc = fpc; v.fdata = fd; v.rdy = rdy; v.br = br; v.bpc = bpc;
        v.ev = ev; v.einst = ei; v.ec = ec; v.epc = epc; v.efr = efr; v.eocc = eocc;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: actual %h required %h", nm, act, req);
        end
    endtask

    task automatic apply(input vec_t v, input bit w64, input string tag);
        @(negedge clk);
        if (w64) begin
            fv64 = v.fv; fpc64 = v.fpc; fd64 = v.fdata; rdy64 = v.rdy; br64 = v.br; bpc64 = v.bpc;
            fv32 = 0; rdy32 = 0; br32 = 0;
        end else begin
            fv32 = v.fv; fpc32 = v.fpc; fd32 = v.fdata[31:0]; rdy32 = v.rdy; br32 = v.br; bpc32 = v.bpc;
            fv64 = 0; rdy64 = 0; br64 = 0;
        end
        #1;
        chk({tag, "_valid"}, w64 ? iv64 : iv32, v.ev);
        chk({tag, "_pc"},    w64 ? pc64 : pc32, v.epc);
        chk({tag, "_ready"}, w64 ? fr64 : fr32, v.efr);
        chk({tag, "_occ"},   w64 ? occ64 : occ32, v.eocc);
        if (v.ev) begin
            chk({tag, "_inst"}, w64 ? inst64 : inst32, v.einst);
            chk({tag, "_isc"},  w64 ? isc64 : isc32, v.ec);
        end
    endtask

    vec_t t32[$];
    vec_t t64[$];

    initial begin
        // 32-bit: basic stream, straddle, stale drop, redirect corner cases
        t32.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 32'h0, 1, 0));
        t32.push_back(mk(1, 32'h0, 64'h00B5_0513, 1, 0, 0, 0, 0, 0, 32'h0, 1, 0));
        t32.push_back(mk(1, 32'h4, 64'h4581_0001, 1, 0, 0, 1, 32'h00B5_0513, 0, 32'h0, 1, 2));
        t32.push_back(mk(0, 0, 0, 1, 0, 0, 1, 32'h0000_0001, 1, 32'h4, 1, 2));
        t32.push_back(mk(0, 0, 0, 1, 0, 0, 1, 32'h0000_4581, 1, 32'h6, 1, 1));
        t32.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 32'h8, 1, 0));
        t32.push_back(mk(0, 0, 0, 1, 1, 32'h0, 0, 0, 0, 32'h8, 1, 0));
        t32.push_back(mk(1, 32'h0, 64'h0513_4501, 1, 0, 0, 0, 0, 0, 32'h0, 1, 0));
        t32.push_back(mk(0, 0, 0, 1, 0, 0, 1, 32'h0000_4501, 1, 32'h0, 1, 2));
        t32.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 32'h2, 1, 1));
        t32.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 32'h2, 1, 1));
        t32.push_back(mk(1, 32'h4, 64'hABCD_00B5, 1, 0, 0, 0, 0, 0, 32'h2, 1, 1));
        t32.push_back(mk(0, 0, 0, 1, 0, 0, 1, 32'h00B5_0513, 0, 32'h2, 1, 3));
        t32.push_back(mk(0, 0, 0, 0, 0, 0, 1, 32'h0000_ABCD, 1, 32'h6, 1, 1));
        t32.push_back(mk(0, 0, 0, 1, 0, 0, 1, 32'h0000_ABCD, 1, 32'h6, 1, 1));
        t32.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 32'h8, 1, 0));
        t32.push_back(mk(1, 32'h8, 64'h0, 1, 1, 32'h102, 0, 0, 0, 32'h8, 1, 0));
        t32.push_back(mk(1, 32'h10, 64'h1111_1111, 1, 0, 0, 0, 0, 0, 32'h102, 1, 0));
        t32.push_back(mk(1, 32'h100, 64'h4505_2222, 1, 0, 0, 0, 0, 0, 32'h102, 1, 0));
        t32.push_back(mk(0, 0, 0, 0, 0, 0, 1, 32'h0000_4505, 1, 32'h102, 1, 1));
        t32.push_back(mk(0, 0, 0, 1, 0, 0, 1, 32'h0000_4505, 1, 32'h102, 1, 1));
        t32.push_back(mk(1, 32'h104, 64'h0513_0001, 1, 0, 0, 0, 0, 0, 32'h104, 1, 0));
        t32.push_back(mk(0, 0, 0, 1, 0, 0, 1, 32'h0000_0001, 1, 32'h104, 1, 2));
        t32.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 32'h106, 1, 1));
        t32.push_back(mk(0, 0, 0, 1, 1, 32'h200, 0, 0, 0, 32'h106, 1, 1));
        t32.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 32'h200, 1, 0));
        t32.push_back(mk(1, 32'h200, 64'h0001_0001, 1, 0, 0, 0, 0, 0, 32'h200, 1, 0));
        t32.push_back(mk(0, 0, 0, 1, 0, 0, 1, 32'h0000_0001, 1, 32'h200, 1, 2));
        t32.push_back(mk(0, 0, 0, 1, 1, 32'h305, 0, 0, 0, 32'h202, 1, 1));
        t32.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 32'h304, 1, 0));

        // 64-bit, reset PC 6: skipped head, backpressure to full, in-order drain
        t64.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h6, 1, 0));
        t64.push_back(mk(1, 32'h0, 64'h0001_3333_2222_1111, 0, 0, 0, 0, 0, 0, 32'h6, 1, 0));
        t64.push_back(mk(1, 32'h8, 64'h4581_00B5_0513_0001, 0, 0, 0, 1, 32'h1, 1, 32'h6, 1, 1));
        t64.push_back(mk(1, 32'h10, 64'h00B5_0513_0001_0001, 0, 0, 0, 1, 32'h1, 1, 32'h6, 0, 5));
        t64.push_back(mk(1, 32'h10, 64'h00B5_0513_0001_0001, 0, 0, 0, 1, 32'h1, 1, 32'h6, 0, 5));
        t64.push_back(mk(1, 32'h10, 64'h00B5_0513_0001_0001, 1, 0, 0, 1, 32'h1, 1, 32'h6, 0, 5));
        t64.push_back(mk(1, 32'h10, 64'h00B5_0513_0001_0001, 1, 0, 0, 1, 32'h1, 1, 32'h8, 1, 4));
        t64.push_back(mk(0, 0, 0, 1, 0, 0, 1, 32'h00B5_0513, 0, 32'hA, 0, 7));
        t64.push_back(mk(0, 0, 0, 1, 0, 0, 1, 32'h0000_4581, 1, 32'hE, 0, 5));
        t64.push_back(mk(0, 0, 0, 1, 0, 0, 1, 32'h0000_0001, 1, 32'h10, 1, 4));
        t64.push_back(mk(0, 0, 0, 1, 0, 0, 1, 32'h0000_0001, 1, 32'h12, 1, 3));
        t64.push_back(mk(0, 0, 0, 1, 0, 0, 1, 32'h00B5_0513, 0, 32'h14, 1, 2));
        t64.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 32'h18, 1, 0));

        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < t32.size(); i++) apply(t32[i], 1'b0, $sformatf("t32_%0d", i));
        for (int i = 0; i < t64.size(); i++) apply(t64[i], 1'b1, $sformatf("t64_%0d", i));

        // Reset mid-stream while a fetch response is being offered
        @(negedge clk);
        fv64 = 0; rdy64 = 0; br64 = 0;
        fv32 = 1; fpc32 = 32'h304; fd32 = 32'h0001_0001; rdy32 = 0; br32 = 0;
        @(negedge clk);
        reset = 1'b1; fpc32 = 32'h308;
        #1;
        chk("mid_pre_valid", iv32, 1'b1);
        chk("mid_pre_occ", occ32, 4'd2);
        @(negedge clk);
        reset = 1'b0; fv32 = 0;
        #1;
        chk("rst_valid", iv32, 1'b0);
        chk("rst_occ", occ32, 4'd0);
        chk("rst_pc", pc32, 32'h0);
        chk("rst_ready", fr32, 1'b1);
        chk("rst64_pc", pc64, 32'h6);
        chk("rst64_occ", occ64, 4'd0);
        @(negedge clk);
        fv32 = 1; fpc32 = 32'h0; fd32 = 32'h0000_0001;
        @(negedge clk);
        fv32 = 0; rdy32 = 1;
        #1;
        chk("post_rst_valid", iv32, 1'b1);
        chk("post_rst_inst", inst32, 32'h1);
        chk("post_rst_pc", pc32, 32'h0);
        chk("post_rst_occ", occ32, 4'd2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
`default_nettype wire
